// File: rtl/matrix_keypad_scanner.sv
// ROWS x COLS key matrix scanner: whole-scan debounce, ghost rejection, row-major codes and a hex history.
// Define KEY_REPEAT_EN to build long-press auto-repeat; without it REPEAT_DELAY/REPEAT_PERIOD are ignored.
module matrix_keypad_scanner #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SETTLE_CYC    = 4,
    parameter int DEB_SCANS     = 3,
    parameter int DIGITS        = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COLS-1:0]     key_v,
    output logic [ROWS-1:0]     key_h,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic [4*DIGITS-1:0] display_num
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(SETTLE_CYC);
    localparam int DW = $clog2(DEB_SCANS + 1);
    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYC - 1);
    localparam logic [DW-1:0] DEB_FULL    = DW'(DEB_SCANS);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_SCANS - 1);

    typedef enum logic {IDLE, SCAN} state_t;
    typedef enum logic [1:0] {HIT_NONE, HIT_ONE, HIT_MULTI} hit_t;

    state_t          state;
    logic [COLS-1:0] v_meta, v_sync;
    logic [RW-1:0]   row;
    logic [SW-1:0]   settle;
    hit_t            acc_hit;
    logic [3:0]      acc_code, cand_code;
    logic [DW-1:0]   press_cnt, release_cnt;

    hit_t            row_hit, scan_hit;
    int              col_sel;
    logic [3:0]      row_code, scan_code;
    logic [DW-1:0]   press_next;
    logic            same_cand, sample_now, scan_end, press_fire, rep_fire, event_now;

    function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] r);
        return ~(ROWS'(1) << r);
    endfunction

    assign sample_now = (state == SCAN) && (settle == LAST_SETTLE);
    assign scan_end   = sample_now && (row == LAST_ROW);
    assign event_now  = press_fire | rep_fire;

    // Classify the current row sample and merge it into the running scan result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        row_hit = HIT_NONE;
        col_sel = 0;
        for (int c = 0; c < COLS; c++) begin
            if (!v_sync[c]) begin
                if (row_hit == HIT_NONE) begin
                    row_hit = HIT_ONE;
                    col_sel = c;
                end else begin
                    row_hit = HIT_MULTI;
                end
            end
        end
        row_code  = 4'(int'(row) * COLS + col_sel);
        scan_hit  = acc_hit;
        scan_code = acc_code;
        if (row_hit == HIT_MULTI || (row_hit == HIT_ONE && acc_hit != HIT_NONE)) begin
            scan_hit = HIT_MULTI;
        end else if (row_hit == HIT_ONE) begin
            scan_hit  = HIT_ONE;
            scan_code = row_code;
        end
    end

    always_comb begin
        same_cand = (press_cnt != '0) && (scan_code == cand_code);
        if (!same_cand)                press_next = DW'(1);
        else if (press_cnt == DEB_FULL) press_next = press_cnt;
        else                            press_next = press_cnt + 1'b1;
        // Fire once per run, when the count first reaches full, unless it is the code already held.
        press_fire = (scan_hit == HIT_ONE) && (press_next == DEB_FULL)
                  && !(same_cand && press_cnt == DEB_FULL)
                  && (!key_held || scan_code != key_code);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_meta      <= '1;
            v_sync      <= '1;
            state       <= IDLE;
            key_h       <= '0;
            row         <= '0;
            settle      <= '0;
            acc_hit     <= HIT_NONE;
            acc_code    <= '0;
            cand_code   <= '0;
            press_cnt   <= '0;
            release_cnt <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            display_num <= '0;
        end else begin
            v_meta    <= key_v;
            v_sync    <= v_meta;
            key_valid <= 1'b0;
            case (state)
                IDLE: begin
                    key_h <= '0;
                    if (v_sync != '1) begin
                        state       <= SCAN;
                        row         <= '0;
                        settle      <= '0;
                        key_h       <= row_drive('0);
                        acc_hit     <= HIT_NONE;
                        press_cnt   <= '0;
                        release_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (!sample_now) begin
                        settle <= settle + 1'b1;
                    end else if (!scan_end) begin
                        settle   <= '0;
                        row      <= row + 1'b1;
                        key_h    <= row_drive(row + 1'b1);
                        acc_hit  <= scan_hit;
                        acc_code <= scan_code;
                    end else begin
                        settle  <= '0;
                        row     <= '0;
                        key_h   <= row_drive('0);
                        acc_hit <= HIT_NONE;
                        if (event_now) begin
                            key_valid   <= 1'b1;
                            key_code    <= scan_code;
                            key_held    <= 1'b1;
                            display_num <= (display_num << 4) | (4*DIGITS)'(scan_code);
                        end
                        case (scan_hit)
                            HIT_NONE: begin
                                press_cnt <= '0;
                                if (release_cnt == DEB_LAST) begin
                                    release_cnt <= '0;
                                    key_held    <= 1'b0;
                                    state       <= IDLE;
                                    key_h       <= '0;
                                end else begin
                                    release_cnt <= release_cnt + 1'b1;
                                end
                            end
                            HIT_ONE: begin
                                release_cnt <= '0;
                                press_cnt   <= press_next;
                                cand_code   <= scan_code;
                            end
                            default: begin
                                press_cnt   <= '0;
                                release_cnt <= '0;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RPW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

    logic [RPW-1:0] rep_cnt, rep_next;
    logic           rep_active, rep_first, rep_same;

    always_comb begin
        rep_next = rep_cnt + 1'b1;
        rep_same = (scan_hit == HIT_ONE) && key_held && (scan_code == key_code) && rep_active;
        rep_fire = 1'b0;
        if (rep_same)
            rep_fire = rep_first ? (rep_next == RPW'(REPEAT_DELAY)) : (rep_next == RPW'(REPEAT_PERIOD));
    end

    // Timing restarts at every event and is dropped by any scan that is not the held key alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt    <= '0;
            rep_active <= 1'b0;
            rep_first  <= 1'b1;
        end else if (scan_end) begin
            if (press_fire) begin
                rep_cnt    <= '0;
                rep_active <= 1'b1;
                rep_first  <= 1'b1;
            end else if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else if (rep_same) begin
                rep_cnt <= rep_next;
            end else begin
                rep_cnt    <= '0;
                rep_active <= 1'b0;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner: a passive 4x4 key matrix model driven by key_h.
// Repeat expectations follow KEY_REPEAT_EN when the bundle is built with it.
module tb_matrix_keypad_scanner;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam logic [ROWS-1:0] LAST_DRV = 4'b0111;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [COLS-1:0]   key_v;
    logic [ROWS-1:0]   key_h;
    logic [3:0]        key_code;
    logic              key_valid;
    logic              key_held;
    logic [15:0]       display_num;

    logic [15:0] pressed = '0;  // bit index = row*COLS + col = key code
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ev_count = 0;
    int ev_base  = 0;
    int ev_exp   = 0;
    logic prev_valid = 1'b0;

    matrix_keypad_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .key_v       (key_v),
        .key_h       (key_h),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .display_num (display_num)
    );

    always #5 clk = ~clk;

    always_comb begin
        key_v = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS + c] && !key_h[r]) key_v[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            ev_count++;
            check("valid_one_cycle", {31'b0, prev_valid}, 32'd0);
        end
        prev_valid = key_valid;
    end

    // Returns #1 after the negedge that follows the end of the n-th full scan from now.
    task automatic wait_scans(input int n);
        logic [ROWS-1:0] prev;
        logic found;
        int budget;
        for (int s = 0; s < n; s++) begin
            prev   = key_h;
            found  = 1'b0;
            budget = 200;
            while (!found && budget > 0) begin
                @(negedge clk);
                found = (prev == LAST_DRV) && (key_h != LAST_DRV);
                prev  = key_h;
                budget--;
            end
            check("scan_seen", {31'b0, found}, 32'd1);
            if (!found) return;
        end
        #1;
    endtask

    task automatic press_release(input int code, input logic [15:0] exp_disp);
        pressed = 16'(1) << code;
        wait_scans(3);
        check("seq_code", {28'b0, key_code}, code);
        check("seq_display", {16'b0, display_num}, {16'b0, exp_disp});
        pressed = '0;
        wait_scans(3);
        check("seq_released", {31'b0, key_held}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_h", {28'b0, key_h}, 32'd0);
        check("rst_code", {28'b0, key_code}, 32'd0);
        check("rst_valid", {31'b0, key_valid}, 32'd0);
        check("rst_held", {31'b0, key_held}, 32'd0);
        check("rst_display", {16'b0, display_num}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_key_h", {28'b0, key_h}, 32'd0);

        // 1: row 2 / col 1 held for ten scans.
        pressed = 16'(1) << 9;
        wait_scans(2);
        check("t1_no_early_event", ev_count, 0);
        wait_scans(1);
        check("t1_valid", {31'b0, key_valid}, 32'd1);
        check("t1_events", ev_count, 1);
        check("t1_code", {28'b0, key_code}, 32'h9);
        check("t1_display", {16'b0, display_num}, 32'h0009);
        check("t1_held", {31'b0, key_held}, 32'd1);
        wait_scans(7);
        check("t1_single_event", ev_count, 1);
        pressed = '0;
        wait_scans(2);
        check("t1_held_during_release", {31'b0, key_held}, 32'd1);
        wait_scans(1);
        check("t1_released", {31'b0, key_held}, 32'd0);
        check("t1_idle", {28'b0, key_h}, 32'd0);
        check("t1_no_release_event", ev_count, 1);

        // 2: history shifting and wrap.
        press_release(1, 16'h0091);
        press_release(10, 16'h091A);
        press_release(3, 16'h91A3);
        press_release(15, 16'h1A3F);
        press_release(0, 16'hA3F0);
        check("t2_events", ev_count, 6);

        // 3: code 6 bounces for six scans, ending released, then settles.
        ev_base = ev_count;
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? (16'(1) << 6) : 16'h0000;
            wait_scans(1);
        end
        check("t3_no_bounce_event", ev_count, ev_base);
        pressed = 16'(1) << 6;
        wait_scans(2);
        check("t3_not_yet", ev_count, ev_base);
        wait_scans(1);
        check("t3_event", ev_count, ev_base + 1);
        check("t3_code", {28'b0, key_code}, 32'h6);
        check("t3_display", {16'b0, display_num}, 32'h3F06);
        pressed = '0;
        wait_scans(3);

        // 4: codes 5 and 6 together (ghost), then 6 lifted.
        ev_base = ev_count;
        pressed = (16'(1) << 5) | (16'(1) << 6);
        wait_scans(6);
        check("t4_no_multi_event", ev_count, ev_base);
        pressed = 16'(1) << 5;
        wait_scans(2);
        check("t4_not_yet", ev_count, ev_base);
        wait_scans(1);
        check("t4_event", ev_count, ev_base + 1);
        check("t4_code", {28'b0, key_code}, 32'h5);
        check("t4_display", {16'b0, display_num}, 32'hF065);
        pressed = '0;
        wait_scans(3);
        check("t4_released", {31'b0, key_held}, 32'd0);

        // 5: reset pulse while a key is held.
        pressed = 16'(1) << 9;
        wait_scans(3);
        check("t5_held", {31'b0, key_held}, 32'd1);
        check("t5_display_before", {16'b0, display_num}, 32'h0659);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pressed = '0;
        check("t5_key_h", {28'b0, key_h}, 32'd0);
        check("t5_code", {28'b0, key_code}, 32'd0);
        check("t5_valid", {31'b0, key_valid}, 32'd0);
        check("t5_held_cleared", {31'b0, key_held}, 32'd0);
        check("t5_display", {16'b0, display_num}, 32'd0);
        ev_base = ev_count;
        repeat (100) @(negedge clk);
        check("t5_stays_idle", {28'b0, key_h}, 32'd0);
        check("t5_no_spurious", ev_count, ev_base);

        // 6: code C held for twenty scans.
        ev_base = ev_count;
        ev_exp  = 0;
        pressed = 16'(1) << 12;
        for (int s = 1; s <= 20; s++) begin
            wait_scans(1);
`ifdef KEY_REPEAT_EN
            if (s == 3 || s == 11 || s == 15 || s == 19) ev_exp++;
`else
            if (s == 3) ev_exp++;
`endif
            check("t6_events", ev_count, ev_base + ev_exp);
        end
`ifdef KEY_REPEAT_EN
        check("t6_display", {16'b0, display_num}, 32'hCCCC);
`else
        check("t6_display", {16'b0, display_num}, 32'h000C);
`endif
        check("t6_code", {28'b0, key_code}, 32'hC);
        pressed = '0;
        wait_scans(3);
        check("t6_released", {31'b0, key_held}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
